// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer and its UI: note codes, FSM
// state encoding and the note-code to one-hot generator select decode.
package melody_pkg;

  localparam logic [2:0] NOTE_REST = 3'd0;
  localparam logic [2:0] NOTE_DOI  = 3'd1;
  localparam logic [2:0] NOTE_RE   = 3'd2;
  localparam logic [2:0] NOTE_MI   = 3'd3;
  localparam logic [2:0] NOTE_FA   = 3'd4;
  localparam logic [2:0] NOTE_SO   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_PLAY  = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  // Codes 6 and 7 fall through to silence, same as an explicit rest.
  function automatic logic [4:0] note_to_select(input logic [2:0] note);
    logic [4:0] sel;
    sel = 5'b00000;
    case (note)
      NOTE_DOI: sel = 5'b00001;
      NOTE_RE:  sel = 5'b00010;
      NOTE_MI:  sel = 5'b00100;
      NOTE_FA:  sel = 5'b01000;
      NOTE_SO:  sel = 5'b10000;
      default:  sel = 5'b00000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/melody_score_ram.sv
// Score storage: SEQ_LEN x 8 distributed RAM, one synchronous write port and
// one asynchronous read port. A same-cycle read of the written address sees old data.
module melody_score_ram #(
  parameter int SEQ_LEN = 16,
  parameter int AW      = $clog2(SEQ_LEN)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [SEQ_LEN];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/melody_sequencer.sv
// Steps through a stored (note, duration) score, driving the note generator's
// one-hot select with a silent gap at the end of every note; supports loop and stop.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int SEQ_LEN    = 16,
  parameter int TICK_DIV   = 12_500_000,
  parameter int GAP_CYCLES = 5_000_000,
  localparam int AW        = $clog2(SEQ_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [2:0]    wr_note,
  input  logic [4:0]    wr_dur,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  output logic [4:0]    select,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] step
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] PLAY_END = CW'(TICK_DIV - GAP_CYCLES - 1);
  localparam logic [AW-1:0] STEP_LAST = AW'(SEQ_LEN - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    ticks_q, ticks_d;
  logic [4:0]    select_q, select_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [7:0]    rd_data;
  logic [2:0]    rd_note;
  logic [4:0]    rd_dur;
  logic          end_of_score;

  melody_score_ram #(
    .SEQ_LEN (SEQ_LEN),
    .AW      (AW)
  ) u_score (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({wr_note, wr_dur}),
    .rd_addr (step_q),
    .rd_data (rd_data)
  );

  assign rd_note = rd_data[7:5];
  assign rd_dur  = rd_data[4:0];

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    ticks_d      = ticks_q;
    select_d     = select_q;
    done_d       = 1'b0;
    end_of_score = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          step_d  = '0;
        end
      end
      S_FETCH: begin
        if (rd_dur == 5'd0) begin
          end_of_score = 1'b1;
        end else begin
          ticks_d  = rd_dur;
          cnt_d    = '0;
          select_d = note_to_select(rd_note);
          state_d  = S_PLAY;
        end
      end
      S_PLAY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          ticks_d = ticks_q - 5'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        // The gap is carved out of the tail of the last tick, so the timer keeps running.
        if (ticks_q == 5'd1 && cnt_q == PLAY_END) begin
          select_d = 5'b00000;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (step_q == STEP_LAST) begin
            end_of_score = 1'b1;
          end else begin
            step_d  = step_q + AW'(1);
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (end_of_score) begin
      select_d = 5'b00000;
      if (loop) begin
        step_d  = '0;
        state_d = S_FETCH;
      end else begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end

    if (stop) begin
      state_d  = S_IDLE;
      select_d = 5'b00000;
      done_d   = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      cnt_q    <= '0;
      ticks_q  <= '0;
      select_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      ticks_q  <= ticks_d;
      select_q <= select_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign select = select_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign step   = step_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with TICK_DIV=10, GAP_CYCLES=2, SEQ_LEN=4.
module tb_melody_sequencer;

  localparam int SEQ_LEN    = 4;
  localparam int TICK_DIV   = 10;
  localparam int GAP_CYCLES = 2;
  localparam int AW         = 2;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_note;
  logic [4:0]    wr_dur;
  logic          start;
  logic          stop;
  logic          loop;
  logic [4:0]    select;
  logic          busy;
  logic          done;
  logic [AW-1:0] step;

  int total;
  int bad;

  // expected notes of one pass: {select[4:0], play_len[4:0]}
  logic [9:0] exp_q[$];

  melody_sequencer #(
    .SEQ_LEN    (SEQ_LEN),
    .TICK_DIV   (TICK_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_note (wr_note),
    .wr_dur  (wr_dur),
    .start   (start),
    .stop    (stop),
    .loop    (loop),
    .select  (select),
    .busy    (busy),
    .done    (done),
    .step    (step)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [2:0] n, input logic [4:0] d);
    wr_en = 1'b1; wr_addr = a; wr_note = n; wr_dur = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered while sampling a FETCH cycle; leaves sampling the cycle after GAP ends.
  task automatic play_note(input string tag, input logic [AW-1:0] idx,
                           input logic [4:0] sel, input int len);
    int n;
    check({tag, "_fetch_busy"}, busy, 1);
    check({tag, "_fetch_step"}, step, idx);
    check({tag, "_fetch_sel"}, select, 0);
    tick();
    wr_en = 1'b0;
    n = 0;
    while (select === sel && n < 100) begin
      n++;
      tick();
    end
    check({tag, "_play_len"}, n, len);
    check({tag, "_gap_sel"}, select, 0);
    check({tag, "_gap_done"}, done, 0);
    tick();
    tick();
  endtask

  // scoreboard: play one full pass from the queue
  task automatic play_pass(input string tag);
    logic [9:0] e;
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      play_note($sformatf("%s_s%0d", tag, i), AW'(i), e[9:5], int'(e[4:0]));
      i++;
    end
  endtask

  task automatic load_pass();
    exp_q.push_back({5'b00001, 5'd8});
    exp_q.push_back({5'b10000, 5'd18});
    exp_q.push_back({5'b00010, 5'd8});
    exp_q.push_back({5'b01000, 5'd8});
  endtask

  initial begin
    int done_seen;
    total = 0; bad = 0;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_note = '0; wr_dur = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    check("rst_select", select, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_step", step, 0);

    // empty score
    for (int a = 0; a < SEQ_LEN; a++) wr(AW'(a), 3'd0, 5'd0);
    pulse_start();
    check("empty_busy", busy, 1);
    check("empty_done0", done, 0);
    check("empty_sel", select, 0);
    tick();
    check("empty_done", done, 1);
    check("empty_busy_end", busy, 0);
    check("empty_sel_end", select, 0);
    tick();
    check("empty_done_pulse", done, 0);

    // single note then end marker
    wr(2'd0, 3'd3, 5'd3);
    wr(2'd1, 3'd0, 5'd0);
    pulse_start();
    play_note("mi", 2'd0, 5'b00100, 28);
    check("mi_fetch2_step", step, 1);
    check("mi_fetch2_busy", busy, 1);
    check("mi_fetch2_done", done, 0);
    tick();
    check("mi_done", done, 1);
    check("mi_busy_end", busy, 0);
    tick();
    check("mi_done_pulse", done, 0);

    // full score, no end marker
    wr(2'd0, 3'd1, 5'd1);
    wr(2'd1, 3'd5, 5'd2);
    wr(2'd2, 3'd2, 5'd1);
    wr(2'd3, 3'd4, 5'd1);
    pulse_start();
    load_pass();
    play_pass("full");
    check("full_done", done, 1);
    check("full_busy_end", busy, 0);
    check("full_sel_end", select, 0);

    // loop: wraps to step 0 with no done, then drop loop
    tick();
    loop = 1'b1;
    pulse_start();
    load_pass();
    play_pass("loop1");
    check("loop_wrap_done", done, 0);
    check("loop_wrap_busy", busy, 1);
    check("loop_wrap_step", step, 0);
    loop = 1'b0;
    load_pass();
    play_pass("loop2");
    check("loop_end_done", done, 1);
    check("loop_end_busy", busy, 0);

    // stop mid play of step 1
    tick();
    pulse_start();
    play_note("stp_s0", 2'd0, 5'b00001, 8);
    tick(); tick(); tick(); tick(); tick();
    check("stop_pre_sel", select, 5'b10000);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_sel", select, 0);
    check("stop_busy", busy, 0);
    check("stop_done", done, 0);
    done_seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("stop_quiet", done_seen, 0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 0);
    tick();
    check("startstop_busy2", busy, 0);
    check("startstop_sel", select, 0);

    // write to the playing step: old data this pass, new data next pass
    wr(2'd1, 3'd2, 5'd2);
    loop = 1'b1;
    pulse_start();
    play_note("wr_s0", 2'd0, 5'b00001, 8);
    wr_en = 1'b1; wr_addr = 2'd1; wr_note = 3'd5; wr_dur = 5'd1;
    play_note("wr_s1", 2'd1, 5'b00010, 18);
    play_note("wr_s2", 2'd2, 5'b00010, 8);
    play_note("wr_s3", 2'd3, 5'b01000, 8);
    play_note("wr2_s0", 2'd0, 5'b00001, 8);
    loop = 1'b0;
    play_note("wr2_s1", 2'd1, 5'b10000, 8);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("wr_stop_busy", busy, 0);

    // reset mid note keeps score
    pulse_start();
    tick(); tick();
    check("rstmid_pre_sel", select, 5'b00001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_sel", select, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_step", step, 0);
    pulse_start();
    play_note("rstmid_s0", 2'd0, 5'b00001, 8);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
